fifo_nic_to_noc: RTL and testbench
==================================

# fifo_nic_to_noc

NIC-to-NoC output stage: holds one "pointer" per NoC virtual channel (VN×VC). Each pointer binds a VC to one NIC output buffer while a packet is in flight. The block forwards NoC credits to the owning buffer and registers outgoing flits onto the NoC link. It sits between the wishbone slave interface (buffers), the VC allocator, and the router input port.

## Interface
Parameters:
- N_TOT_OF_VC, default `N_OF_VC*`N_OF_VN` (6): number of VCs/pointers.
- N_BITS_POINTER, default clog2(`N_FIFO_OUT_BUFFER) (3): width of an output-buffer id.
- FLIT_WIDTH, default `FLIT_WIDTH`: flit width.

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous active-high reset.
- credit_signal_i  in  N_TOT_OF_VC  per-VC credit pulse from NoC.
- free_signal_i  in  N_TOT_OF_VC  per-VC "downstream VC freed" pulse from NoC.
- out_link_o  out  FLIT_WIDTH  flit to NoC.
- is_valid_o  out  1  out_link_o valid.
- g_fifo_pointer_i  in  N_TOT_OF_VC  per-VC grant pulse; binds the VC to a buffer.
- g_fifo_out_buffer_id_i  in  N_TOT_OF_VC*N_BITS_POINTER  buffer id per VC; slice v = bits [v*N_BITS_POINTER +: N_BITS_POINTER].
- release_pointer_i  in  N_TOT_OF_VC  per-VC release pulse (tail flit sent).
- credit_signal_o  out  N_TOT_OF_VC  credits forwarded to buffer side.
- fifo_pointed_o  out  N_TOT_OF_VC*N_BITS_POINTER  buffer id held by each pointer, same slicing.
- in_link_i  in  FLIT_WIDTH  flit from buffer side.
- is_valid_i  in  1  in_link_i valid.
- fifo_pointer_state_o  out  N_TOT_OF_VC  1 = VC busy (not IDLE), to VC allocator.

## Operation
- Per-VC state machine: IDLE, ALLOC, WAIT_FREE. Each VC also holds an id register.
- IDLE:
  - grant[v] → ALLOC, and id[v] ← slice v of g_fifo_out_buffer_id_i.
  - free and release are ignored.
- ALLOC:
  - release[v] & !free[v] → WAIT_FREE.
  - release[v] & free[v] → IDLE.
  - free alone is ignored.
  - grant is ignored.
- WAIT_FREE:
  - free[v] & grant[v] → ALLOC with the new id.
  - free[v] alone → IDLE.
  - grant alone is ignored.
  - release is ignored.
- fifo_pointer_state_o[v] = (state[v] != IDLE).
- fifo_pointed_o slice v = id[v] when not IDLE, else 0.
- credit_signal_o[v] = credit_signal_i[v] & (state[v] != IDLE). Combinational; credits are still forwarded in WAIT_FREE.
- Flit path:
  - is_valid_o ← is_valid_i, registered.
  - out_link_o ← in_link_i, registered, only when is_valid_i=1; otherwise it holds.
- All VCs are independent; any mix of simultaneous events on different VCs is legal.

## Timing
- Reset (asynchronous, immediate): every state = IDLE, id = 0, out_link_o = 0, is_valid_o = 0. So fifo_pointer_state_o = 0, fifo_pointed_o = 0, credit_signal_o = 0.
- Reset asserted mid-packet drops all bindings at once.
- State and id updates take effect at the clk edge where the pulse is sampled. Outputs reflect them in the following cycle (1-cycle latency).
- Credit forwarding has 0-cycle latency and is gated by the current (pre-edge) state.
- Flit latency is 1 cycle.

## Structure
- Shared package/defines holds the state encodings (IDLE=2'd0, ALLOC=2'd1, WAIT_FREE=2'd2), `N_OF_VC, `N_OF_VN, `N_FIFO_OUT_BUFFER, `FLIT_WIDTH and clog2 (NIC_utils).
- One sub-module, nic2noc_vc_pointer: a single VC's FSM, id register and credit gate. Instantiate it N_TOT_OF_VC times with a generate loop.
- The top level adds the flit register.

## Test plan
All cases use N_TOT_OF_VC=6, N_BITS_POINTER=3.
- Reset: hold rst 2 cycles → all outputs 0, and they stay 0 with no stimulus.
- Grant: g_fifo_pointer_i=6'b001010, ids=18'b000000010000011001 → next cycle fifo_pointer_state_o=6'b001010, VC1 id=3'b011, VC3 id=3'b010. Then grant 6'b000001 → state 6'b001011, VC0 id=3'b001.
- Release/credit: release 6'b001001 → state stays 6'b001011. Next cycle credit_signal_i=6'b001000 → credit_signal_o=6'b001000 in the same cycle. Credit on an IDLE VC (e.g. 6'b100000) → credit_signal_o=0.
- Simultaneous: grant 6'b000001 + free 6'b001001 + release 6'b000010 →
  - VC0 back to ALLOC with id 001.
  - VC3 goes IDLE; its fifo_pointed_o slice = 0.
  - VC1 goes WAIT_FREE.
  - state = 6'b000011.
- Illegal grants: grant on an ALLOC VC keeps the old id. Free on an ALLOC VC has no effect. Release+free together on an ALLOC VC → IDLE in one cycle.
- Flit path: in_link_i=X with is_valid_i=1 → out_link_o=X and is_valid_o=1 one cycle later. Then is_valid_i=0 → is_valid_o=0 and out_link_o holds X.

Source files
------------

// File: rtl/fifo_nic_to_noc_pkg.sv
// Shared constants, pointer state encoding and helpers for the NIC-to-NoC output stage.
package fifo_nic_to_noc_pkg;

    localparam int N_OF_VC           = 2;
    localparam int N_OF_VN           = 3;
    localparam int N_FIFO_OUT_BUFFER = 8;
    localparam int NIC_FLIT_WIDTH    = 32;

    // Ceiling log2, usable in constant expressions; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Per-VC pointer state.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ALLOC     = 2'd1,
        WAIT_FREE = 2'd2
    } ptr_state_e;

endpackage

// File: rtl/fifo_nic_to_noc_vc_pointer.sv
// One VC pointer: binds the VC to an output buffer id while a packet is in
// flight, and passes NoC credits through only while the VC is bound.
module nic2noc_vc_pointer
    import fifo_nic_to_noc_pkg::*;
#(
    parameter int N_BITS_POINTER = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      grant,
    input  logic                      free,
    input  logic                      rel,
    input  logic [N_BITS_POINTER-1:0] buf_id,
    input  logic                      credit_in,
    output logic                      credit_out,
    output logic                      busy,
    output logic [N_BITS_POINTER-1:0] id_pointed
);

    ptr_state_e                state;
    logic [N_BITS_POINTER-1:0] id;

    // Pointer FSM and bound buffer id; a new id is latched only on an accepted grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        state <= ALLOC;
                        id    <= buf_id;
                    end
                end
                ALLOC: begin
                    // Tail flit gone: if the downstream VC is already free we
                    // can skip waiting for it.
                    if (rel) begin
                        state <= free ? IDLE : WAIT_FREE;
                    end
                end
                WAIT_FREE: begin
                    // A grant arriving together with free rebinds immediately.
                    if (free) begin
                        if (grant) begin
                            state <= ALLOC;
                            id    <= buf_id;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Credits still flow in WAIT_FREE: the downstream VC is not yet released.
    assign busy       = (state != IDLE);
    assign credit_out = credit_in & busy;
    assign id_pointed = busy ? id : '0;

endmodule

// File: rtl/fifo_nic_to_noc.sv
// NIC-to-NoC output stage: one pointer per VC plus the registered flit link.
module fifo_nic_to_noc
    import fifo_nic_to_noc_pkg::*;
#(
    parameter int N_TOT_OF_VC    = N_OF_VC * N_OF_VN,
    parameter int N_BITS_POINTER = clog2(N_FIFO_OUT_BUFFER),
    parameter int FLIT_WIDTH     = NIC_FLIT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_TOT_OF_VC-1:0]                credit_signal_i,
    input  logic [N_TOT_OF_VC-1:0]                free_signal_i,
    output logic [FLIT_WIDTH-1:0]                 out_link_o,
    output logic                                  is_valid_o,
    input  logic [N_TOT_OF_VC-1:0]                g_fifo_pointer_i,
    input  logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] g_fifo_out_buffer_id_i,
    input  logic [N_TOT_OF_VC-1:0]                release_pointer_i,
    output logic [N_TOT_OF_VC-1:0]                credit_signal_o,
    output logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] fifo_pointed_o,
    input  logic [FLIT_WIDTH-1:0]                 in_link_i,
    input  logic                                  is_valid_i,
    output logic [N_TOT_OF_VC-1:0]                fifo_pointer_state_o
);

    logic [FLIT_WIDTH-1:0] flit_p1;
    logic                  vld_p1;

    // One independent pointer per VC.
    for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
        nic2noc_vc_pointer #(
            .N_BITS_POINTER(N_BITS_POINTER)
        ) u_ptr (
            .clk        (clk),
            .rst        (rst),
            .grant      (g_fifo_pointer_i[v]),
            .free       (free_signal_i[v]),
            .rel        (release_pointer_i[v]),
            .buf_id     (g_fifo_out_buffer_id_i[v*N_BITS_POINTER +: N_BITS_POINTER]),
            .credit_in  (credit_signal_i[v]),
            .credit_out (credit_signal_o[v]),
            .busy       (fifo_pointer_state_o[v]),
            .id_pointed (fifo_pointed_o[v*N_BITS_POINTER +: N_BITS_POINTER])
        );
    end

    // Stage p0 -> p1: link register; the flit only updates on a valid beat so the link holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= is_valid_i;
            if (is_valid_i) begin
                flit_p1 <= in_link_i;
            end
        end
    end

    assign out_link_o = flit_p1;
    assign is_valid_o = vld_p1;

endmodule

// File: tb/tb_fifo_nic_to_noc.sv
// Self-checking bench for fifo_nic_to_noc: directed scenarios plus random
// stimulus against a behavioural binding model.
module tb_fifo_nic_to_noc;

    localparam int NV = 6;
    localparam int NB = 3;
    localparam int FW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NV-1:0]     credit_i, free_i, grant_i, rel_i;
    logic [NV*NB-1:0]  ids_i;
    logic [FW-1:0]     in_link;
    logic              vin;
    logic [FW-1:0]     out_link;
    logic              vout;
    logic [NV-1:0]     credit_o, state_o;
    logic [NV*NB-1:0]  pointed_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: is the VC bound, is it waiting for the downstream free, which buffer.
    bit           m_bound [NV];
    bit           m_wait  [NV];
    logic [NB-1:0] m_id   [NV];
    logic [FW-1:0] m_link;
    bit            m_vld;

    fifo_nic_to_noc #(
        .N_TOT_OF_VC   (NV),
        .N_BITS_POINTER(NB),
        .FLIT_WIDTH    (FW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .credit_signal_i       (credit_i),
        .free_signal_i         (free_i),
        .out_link_o            (out_link),
        .is_valid_o            (vout),
        .g_fifo_pointer_i      (grant_i),
        .g_fifo_out_buffer_id_i(ids_i),
        .release_pointer_i     (rel_i),
        .credit_signal_o       (credit_o),
        .fifo_pointed_o        (pointed_o),
        .in_link_i             (in_link),
        .is_valid_i            (vin),
        .fifo_pointer_state_o  (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [NV-1:0] exp_state();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_bound[v];
        return r;
    endfunction

    function automatic logic [NV*NB-1:0] exp_pointed();
        logic [NV*NB-1:0] r;
        r = '0;
        for (int v = 0; v < NV; v++) if (m_bound[v]) r[v*NB +: NB] = m_id[v];
        return r;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_bound[v] = 0;
            m_wait[v]  = 0;
            m_id[v]    = '0;
        end
        m_link = '0;
        m_vld  = 0;
    endtask

    // Apply the binding rules to the inputs present before the edge.
    task automatic model_step();
        for (int v = 0; v < NV; v++) begin
            if (!m_bound[v]) begin
                if (grant_i[v]) begin
                    m_bound[v] = 1;
                    m_wait[v]  = 0;
                    m_id[v]    = ids_i[v*NB +: NB];
                end
            end else if (!m_wait[v]) begin
                if (rel_i[v]) begin
                    if (free_i[v]) m_bound[v] = 0;
                    else           m_wait[v]  = 1;
                end
            end else if (free_i[v]) begin
                m_wait[v] = 0;
                if (grant_i[v]) m_id[v]    = ids_i[v*NB +: NB];
                else            m_bound[v] = 0;
            end
        end
        if (vin) m_link = in_link;
        m_vld = vin;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        grant_i  = '0;
        free_i   = '0;
        rel_i    = '0;
        credit_i = '0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        clear_pulses();
        credit_i = '1;
        ids_i    = '1;
        vin      = 1'b1;
        in_link  = 32'hDEADBEEF;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (state_o !== 6'b0) begin failures++; $display("FAIL reset_state got=%b exp=%b", state_o, 6'b0); end
        checks++; if (pointed_o !== 18'b0) begin failures++; $display("FAIL reset_pointed got=%h exp=0", pointed_o); end
        checks++; if (credit_o !== 6'b0) begin failures++; $display("FAIL reset_credit got=%b exp=0", credit_o); end
        checks++; if (vout !== 1'b0 || out_link !== 32'h0) begin failures++; $display("FAIL reset_link got=%b/%h exp=0/0", vout, out_link); end
        rst      = 1'b0;
        credit_i = '0;
        ids_i    = '0;
        vin      = 1'b0;
        repeat (3) cycle();
        checks++; if (state_o !== 6'b0 || pointed_o !== 18'b0) begin failures++; $display("FAIL reset_idle got=%b/%h exp=0/0", state_o, pointed_o); end
        checks++; if (vout !== 1'b0 || out_link !== 32'h0) begin failures++; $display("FAIL reset_idle_link got=%b/%h exp=0/0", vout, out_link); end
    endtask

    task automatic test_grant();
        grant_i = 6'b001010;
        ids_i   = 18'b000000010000011001;
        cycle();
        clear_pulses();
        checks++; if (state_o !== 6'b001010) begin failures++; $display("FAIL grant_state got=%b exp=%b", state_o, 6'b001010); end
        checks++; if (pointed_o[5:3] !== 3'b011 || pointed_o[11:9] !== 3'b010) begin failures++; $display("FAIL grant_ids got=%b/%b exp=011/010", pointed_o[5:3], pointed_o[11:9]); end
        checks++; if (pointed_o !== 18'b000000010000011000) begin failures++; $display("FAIL grant_pointed got=%b exp=%b", pointed_o, 18'b000000010000011000); end
        grant_i = 6'b000001;
        ids_i   = 18'b000000000000000001;
        cycle();
        clear_pulses();
        checks++; if (state_o !== 6'b001011) begin failures++; $display("FAIL grant2_state got=%b exp=%b", state_o, 6'b001011); end
        checks++; if (pointed_o !== 18'b000000010000011001) begin failures++; $display("FAIL grant2_pointed got=%b exp=%b", pointed_o, 18'b000000010000011001); end
    endtask

    task automatic test_release_credit();
        rel_i = 6'b001001;
        cycle();
        clear_pulses();
        checks++; if (state_o !== 6'b001011) begin failures++; $display("FAIL release_state got=%b exp=%b", state_o, 6'b001011); end
        credit_i = 6'b001000;
        #1;
        checks++; if (credit_o !== 6'b001000) begin failures++; $display("FAIL credit_wait got=%b exp=%b", credit_o, 6'b001000); end
        credit_i = 6'b000011;
        #1;
        checks++; if (credit_o !== 6'b000011) begin failures++; $display("FAIL credit_bound got=%b exp=%b", credit_o, 6'b000011); end
        credit_i = 6'b100000;
        #1;
        checks++; if (credit_o !== 6'b000000) begin failures++; $display("FAIL credit_idle got=%b exp=%b", credit_o, 6'b0); end
        credit_i = '0;
    endtask

    task automatic test_simultaneous();
        grant_i = 6'b000001;
        ids_i   = 18'b000000000000000001;
        free_i  = 6'b001001;
        rel_i   = 6'b000010;
        cycle();
        clear_pulses();
        checks++; if (state_o !== 6'b000011) begin failures++; $display("FAIL simul_state got=%b exp=%b", state_o, 6'b000011); end
        checks++; if (pointed_o[11:9] !== 3'b000) begin failures++; $display("FAIL simul_vc3_id got=%b exp=000", pointed_o[11:9]); end
        checks++; if (pointed_o !== 18'b000000000000011001) begin failures++; $display("FAIL simul_pointed got=%b exp=%b", pointed_o, 18'b000000000000011001); end
    endtask

    task automatic test_illegal();
        // Grant on a bound VC must not overwrite its id.
        grant_i = 6'b000001;
        ids_i   = 18'b000000000000000111;
        cycle();
        clear_pulses();
        checks++; if (pointed_o[2:0] !== 3'b001 || state_o !== 6'b000011) begin failures++; $display("FAIL illegal_grant got=%b/%b exp=001/000011", pointed_o[2:0], state_o); end
        free_i = 6'b000001;
        cycle();
        clear_pulses();
        checks++; if (state_o !== 6'b000011) begin failures++; $display("FAIL free_on_alloc got=%b exp=%b", state_o, 6'b000011); end
        // VC1 is waiting for free: lone grant and release are both ignored.
        grant_i = 6'b000010;
        ids_i   = 18'b000000000000101000;
        rel_i   = 6'b000010;
        cycle();
        clear_pulses();
        checks++; if (pointed_o[5:3] !== 3'b011 || state_o !== 6'b000011) begin failures++; $display("FAIL wait_ignore got=%b/%b exp=011/000011", pointed_o[5:3], state_o); end
        rel_i  = 6'b000001;
        free_i = 6'b000001;
        cycle();
        clear_pulses();
        checks++; if (state_o !== 6'b000010 || pointed_o[2:0] !== 3'b000) begin failures++; $display("FAIL rel_free_idle got=%b/%b exp=000010/000", state_o, pointed_o[2:0]); end
        free_i = 6'b000010;
        cycle();
        clear_pulses();
        checks++; if (state_o !== 6'b000000) begin failures++; $display("FAIL wait_free_idle got=%b exp=%b", state_o, 6'b0); end
    endtask

    task automatic test_flit();
        in_link = 32'hA5A51234;
        vin     = 1'b1;
        cycle();
        checks++; if (vout !== 1'b1 || out_link !== 32'hA5A51234) begin failures++; $display("FAIL flit_valid got=%b/%h exp=1/a5a51234", vout, out_link); end
        in_link = 32'h0BADF00D;
        vin     = 1'b0;
        cycle();
        checks++; if (vout !== 1'b0 || out_link !== 32'hA5A51234) begin failures++; $display("FAIL flit_hold got=%b/%h exp=0/a5a51234", vout, out_link); end
    endtask

    task automatic test_random();
        logic [NV-1:0] ec;
        for (int n = 0; n < 400; n++) begin
            grant_i  = 6'($urandom) & 6'($urandom);
            free_i   = 6'($urandom) & 6'($urandom);
            rel_i    = 6'($urandom) & 6'($urandom);
            ids_i    = 18'($urandom);
            credit_i = 6'($urandom);
            in_link  = $urandom;
            vin      = 1'($urandom);
            #1;
            ec = credit_i & exp_state();
            checks++; if (credit_o !== ec) begin failures++; $display("FAIL rnd_credit n=%0d got=%b exp=%b", n, credit_o, ec); end
            cycle();
            checks++; if (state_o !== exp_state()) begin failures++; $display("FAIL rnd_state n=%0d got=%b exp=%b", n, state_o, exp_state()); end
            checks++; if (pointed_o !== exp_pointed()) begin failures++; $display("FAIL rnd_pointed n=%0d got=%h exp=%h", n, pointed_o, exp_pointed()); end
            checks++; if (vout !== m_vld || out_link !== m_link) begin failures++; $display("FAIL rnd_flit n=%0d got=%b/%h exp=%b/%h", n, vout, out_link, m_vld, m_link); end
        end
        clear_pulses();
        vin = 1'b0;
    endtask

    task automatic test_reset_mid();
        grant_i = '1;
        ids_i   = 18'($urandom);
        in_link = 32'h12345678;
        vin     = 1'b1;
        cycle();
        clear_pulses();
        vin = 1'b0;
        checks++; if (state_o !== 6'b111111) begin failures++; $display("FAIL mid_bound got=%b exp=%b", state_o, 6'b111111); end
        credit_i = '1;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (state_o !== 6'b0 || pointed_o !== 18'b0 || credit_o !== 6'b0) begin failures++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/0", state_o, pointed_o, credit_o); end
        checks++; if (vout !== 1'b0 || out_link !== 32'h0) begin failures++; $display("FAIL mid_reset_link got=%b/%h exp=0/0", vout, out_link); end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        credit_i = '0;
        cycle();
        checks++; if (state_o !== 6'b0 || pointed_o !== 18'b0) begin failures++; $display("FAIL post_reset got=%b/%h exp=0/0", state_o, pointed_o); end
    endtask

    initial begin
        test_reset();
        test_grant();
        test_release_credit();
        test_simultaneous();
        test_illegal();
        test_flit();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
